// File: rtl/fifo_calc.sv
// fifo_calc: pops an "a op b =" expression (1-2 digit operands) from a symbol FIFO and evaluates it.
// Define CALC_MUL_EN to make symbol C a multiply; otherwise C is a syntax error and no multiplier exists.
module fifo_calc (
  input  logic       CLK_50M,
  input  logic       reset,
  input  logic       start,
  input  logic       op_emp,
  input  logic [3:0] op_data,
  output logic       op_rd,
  output logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       ovf
);

  typedef enum logic [3:0] {IDLE, RD, CAP, N1, OP, N2, CALC, FIN, ERR} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} oper_t;

  state_t      state_q, state_d;
  state_t      phase_q, phase_d;
  oper_t       oper_q, oper_d;
  logic [3:0]  sym_q, sym_d;
  logic [6:0]  a_q, a_d, b_q, b_d;
  logic [1:0]  na_q, na_d, nb_q, nb_d;
  logic [7:0]  data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;

  logic        sym_is_digit, sym_is_op, sym_is_eq;
  logic        fetch, fail;
  logic [6:0]  acc_a, acc_b;
  logic [14:0] res, mag;
  logic        res_ovf;
  logic [7:0]  res_byte;

  assign sym_is_digit = (sym_q <= 4'd9);
  assign sym_is_eq    = (sym_q == 4'hD);
`ifdef CALC_MUL_EN
  assign sym_is_op    = (sym_q == 4'hA) || (sym_q == 4'hB) || (sym_q == 4'hC);
`else
  assign sym_is_op    = (sym_q == 4'hA) || (sym_q == 4'hB);
`endif

  // Digit accumulate as x*10 + d; the two-digit limit keeps x <= 9 here so 7 bits suffice.
  assign acc_a = (a_q << 3) + (a_q << 1) + {3'b000, sym_q};
  assign acc_b = (b_q << 3) + (b_q << 1) + {3'b000, sym_q};

  always_comb begin
    res = 15'd0;
    case (oper_q)
      OP_ADD:  res = {8'd0, a_q} + {8'd0, b_q};
      OP_SUB:  res = {8'd0, a_q} - {8'd0, b_q};
`ifdef CALC_MUL_EN
      OP_MUL:  res = {8'd0, a_q} * {8'd0, b_q};
`endif
      default: res = 15'd0;
    endcase
    mag      = res[14] ? (~res + 15'd1) : res;
    res_ovf  = (mag > 15'd127);
    res_byte = {res[14], (res_ovf ? 7'h7F : mag[6:0])};
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    oper_d  = oper_q;
    sym_d   = sym_q;
    a_d     = a_q;
    b_d     = b_q;
    na_d    = na_q;
    nb_d    = nb_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    ovf_d   = ovf_q;
    op_rd   = 1'b0;
    fetch   = 1'b0;
    fail    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          busy_d  = 1'b1;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
          a_d     = 7'd0;
          b_d     = 7'd0;
          na_d    = 2'd0;
          nb_d    = 2'd0;
          oper_d  = OP_ADD;
          phase_d = N1;
          state_d = RD;
        end
      end
      RD:  fetch = 1'b1;
      CAP: begin
        sym_d   = op_data;
        state_d = phase_q;
      end
      N1: begin
        if (sym_is_digit && na_q != 2'd2) begin
          a_d   = acc_a;
          na_d  = na_q + 2'd1;
          fetch = 1'b1;
        end else if (sym_is_op && na_q != 2'd0) begin
          case (sym_q)
            4'hA:    oper_d = OP_ADD;
            4'hB:    oper_d = OP_SUB;
            default: oper_d = OP_MUL;
          endcase
          phase_d = OP;
          fetch   = 1'b1;
        end else begin
          fail = 1'b1;
        end
      end
      // First symbol after the operator must be a digit.
      OP: begin
        if (sym_is_digit) begin
          b_d     = {3'b000, sym_q};
          nb_d    = 2'd1;
          phase_d = N2;
          fetch   = 1'b1;
        end else begin
          fail = 1'b1;
        end
      end
      N2: begin
        if (sym_is_digit && nb_q != 2'd2) begin
          b_d   = acc_b;
          nb_d  = nb_q + 2'd1;
          fetch = 1'b1;
        end else if (sym_is_eq) begin
          state_d = CALC;
        end else begin
          fail = 1'b1;
        end
      end
      CALC: begin
        data_d  = res_byte;
        ovf_d   = res_ovf;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = FIN;
      end
      FIN:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // An empty FIFO ends the expression only once the second operand has a digit.
    if (fetch) begin
      if (!op_emp) begin
        op_rd   = 1'b1;
        state_d = CAP;
      end else if (phase_d == N2) begin
        state_d = CALC;
      end else begin
        fail = 1'b1;
      end
    end

    if (fail) begin
      state_d = ERR;
      err_d   = 1'b1;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK_50M or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      phase_q <= N1;
      oper_q  <= OP_ADD;
      sym_q   <= 4'd0;
      a_q     <= 7'd0;
      b_q     <= 7'd0;
      na_q    <= 2'd0;
      nb_q    <= 2'd0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      oper_q  <= oper_d;
      sym_q   <= sym_d;
      a_q     <= a_d;
      b_q     <= b_d;
      na_q    <= na_d;
      nb_q    <= nb_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data = data_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_fifo_calc.sv
// tb_fifo_calc: drives fifo_calc from a behavioural symbol FIFO and compares against
// directed expectations and a token-level expression evaluator.
module tb_fifo_calc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       op_emp;
  logic [3:0] op_data;
  logic       op_rd, busy, done, err, ovf;
  logic [7:0] data;

  logic [3:0] mem [0:1023];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         rd_empty_viol = 0;
  logic       fifo_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [3:0] sym_buf [0:15];
  int         sym_len;
  bit         exp_err, exp_ovf;
  logic [7:0] exp_data;
  int         exp_pops;
  logic [7:0] last_data = 8'h00;

  int obs_cyc, obs_pops;
  bit obs_tmo, obs_done, obs_err, obs_busy, obs_done_after;

`ifdef CALC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  always #10 clk = ~clk;

  assign op_emp = (rd_ptr == wr_ptr);

  fifo_calc dut (
    .CLK_50M (clk),
    .reset   (rst_n),
    .start   (start),
    .op_emp  (op_emp),
    .op_data (op_data),
    .op_rd   (op_rd),
    .data    (data),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .ovf     (ovf)
  );

  // Symbol FIFO: read data appears the cycle after the pop strobe.
  always @(posedge clk) begin
    if (fifo_clr) begin
      rd_ptr <= wr_ptr;
    end else if (op_rd) begin
      if (rd_ptr == wr_ptr) begin
        rd_empty_viol <= rd_empty_viol + 1;
      end else begin
        op_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1;
      end
    end
  end

  task automatic set_expr(input string s);
    int ci;
    sym_len = s.len();
    for (int i = 0; i < sym_len; i++) begin
      ci = int'(s[i]);
      sym_buf[i] = 4'((ci >= 65) ? ci - 55 : ci - 48);
    end
  endtask

  task automatic load_fifo();
    @(negedge clk);
    for (int i = 0; i < sym_len; i++) mem[wr_ptr + i] = sym_buf[i];
    wr_ptr = wr_ptr + sym_len;
  endtask

  task automatic flush_fifo();
    @(negedge clk);
    fifo_clr = 1'b1;
    @(negedge clk);
    fifo_clr = 1'b0;
  endtask

  // Evaluates the token list directly: operand digit counts, one operator, optional '='.
  task automatic model_eval();
    int a, b, na, nb, stage, op, i, s, r, m;
    bit finished, ok;
    a = 0; b = 0; na = 0; nb = 0; stage = 0; op = 0; i = 0;
    finished = 1'b0; ok = 1'b0;
    exp_pops = 0; exp_err = 1'b0; exp_ovf = 1'b0; exp_data = last_data;
    while (!finished) begin
      if (i == sym_len) begin
        ok = (stage == 1 && nb > 0);
        finished = 1'b1;
      end else begin
        s = int'(sym_buf[i]);
        i++;
        exp_pops++;
        if (s <= 9) begin
          if (stage == 0 && na < 2) begin a = a * 10 + s; na++; end
          else if (stage == 1 && nb < 2) begin b = b * 10 + s; nb++; end
          else finished = 1'b1;
        end else if (s == 10 || s == 11 || (s == 12 && MUL_EN)) begin
          if (stage == 0 && na > 0) begin op = s; stage = 1; end
          else finished = 1'b1;
        end else if (s == 13) begin
          ok = (stage == 1 && nb > 0);
          finished = 1'b1;
        end else begin
          finished = 1'b1;
        end
      end
    end
    if (ok) begin
      r = (op == 10) ? a + b : (op == 11) ? a - b : a * b;
      m = (r < 0) ? -r : r;
      exp_ovf = (m > 127);
      if (m > 127) m = 127;
      exp_data = {(r < 0), 7'(m)};
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic run_expr();
    int rd0;
    rd0 = rd_ptr;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    obs_cyc = 0;
    while (!(done || err) && obs_cyc < 100) begin
      @(negedge clk);
      obs_cyc++;
    end
    obs_tmo  = !(done || err);
    obs_done = done;
    obs_err  = err;
    obs_busy = busy;
    obs_pops = rd_ptr - rd0;
    @(negedge clk);
    obs_done_after = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #2;
    checks++;
    if ({op_rd, busy, done, err, ovf, data} !== 13'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %b exp all zero", {op_rd, busy, done, err, ovf, data});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_data = 8'h00;
  endtask

  task automatic test_add();
    set_expr("12A34D");
    load_fifo();
    run_expr();
    checks++;
    if (!obs_done || obs_tmo || obs_err) begin
      errors++;
      $display("[TB] FAIL add_done done=%b err=%b tmo=%b exp done=1 err=0", obs_done, obs_err, obs_tmo);
    end
    checks++;
    if (data !== 8'h2E || ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_data got %h ovf=%b exp 2e ovf=0", data, ovf);
    end
    checks++;
    if (obs_pops != 6 || obs_cyc != 14) begin
      errors++;
      $display("[TB] FAIL add_timing pops=%0d lat=%0d exp pops=6 lat=14", obs_pops, obs_cyc);
    end
    checks++;
    if (obs_done_after !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_done_pulse done stayed %b exp 0", obs_done_after);
    end
    last_data = 8'h2E;
    flush_fifo();
  endtask

  task automatic test_sub();
    set_expr("3B12D");
    load_fifo();
    run_expr();
    checks++;
    if (!obs_done || obs_tmo || data !== 8'h89 || ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sub_data done=%b data=%h ovf=%b exp done=1 data=89 ovf=0", obs_done, data, ovf);
    end
    checks++;
    if (obs_pops != 5 || obs_cyc != 12) begin
      errors++;
      $display("[TB] FAIL sub_timing pops=%0d lat=%0d exp pops=5 lat=12", obs_pops, obs_cyc);
    end
    last_data = 8'h89;
    flush_fifo();
  endtask

  task automatic test_mul();
    set_expr("99C99D");
    load_fifo();
    run_expr();
`ifdef CALC_MUL_EN
    checks++;
    if (!obs_done || obs_tmo || data !== 8'h7F || ovf !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mul_sat done=%b data=%h ovf=%b exp done=1 data=7f ovf=1", obs_done, data, ovf);
    end
    checks++;
    if (obs_pops != 6 || obs_cyc != 14) begin
      errors++;
      $display("[TB] FAIL mul_timing pops=%0d lat=%0d exp pops=6 lat=14", obs_pops, obs_cyc);
    end
    last_data = 8'h7F;
`else
    checks++;
    if (!obs_err || obs_done || obs_tmo || data !== last_data) begin
      errors++;
      $display("[TB] FAIL mul_err err=%b done=%b data=%h exp err=1 done=0 data=%h", obs_err, obs_done, data, last_data);
    end
    checks++;
    if (obs_pops != 3 || (wr_ptr - rd_ptr) != 3) begin
      errors++;
      $display("[TB] FAIL mul_pops pops=%0d left=%0d exp pops=3 left=3", obs_pops, wr_ptr - rd_ptr);
    end
`endif
    flush_fifo();
  endtask

  task automatic test_syntax_err();
    set_expr("A5D");
    load_fifo();
    run_expr();
    checks++;
    if (!obs_err || obs_done || obs_busy || obs_tmo) begin
      errors++;
      $display("[TB] FAIL syn_err err=%b done=%b busy=%b exp err=1 done=0 busy=0", obs_err, obs_done, obs_busy);
    end
    checks++;
    if (obs_pops != 1 || (wr_ptr - rd_ptr) != 2 || mem[rd_ptr] !== 4'h5 || mem[rd_ptr + 1] !== 4'hD) begin
      errors++;
      $display("[TB] FAIL syn_left pops=%0d left=%0d exp pops=1 left=2 (5,D)", obs_pops, wr_ptr - rd_ptr);
    end
    checks++;
    if (data !== last_data) begin
      errors++;
      $display("[TB] FAIL syn_data got %h exp %h", data, last_data);
    end
    flush_fifo();
  endtask

  task automatic test_no_equals();
    set_expr("7B7");
    load_fifo();
    run_expr();
    checks++;
    if (!obs_done || obs_tmo || data !== 8'h00 || ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL noeq_data done=%b data=%h ovf=%b exp done=1 data=00 ovf=0", obs_done, data, ovf);
    end
    checks++;
    if (obs_pops != 3 || obs_cyc != 8) begin
      errors++;
      $display("[TB] FAIL noeq_timing pops=%0d lat=%0d exp pops=3 lat=8", obs_pops, obs_cyc);
    end
    last_data = 8'h00;
    flush_fifo();
  endtask

  task automatic test_start_while_busy();
    int rd0, cyc;
    set_expr("5A4D7A1D");
    load_fifo();
    rd0 = rd_ptr;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(done || err) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 3);
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || cyc != 10 || data !== 8'h09) begin
      errors++;
      $display("[TB] FAIL busy_start_result done=%b lat=%0d data=%h exp done=1 lat=10 data=09", done, cyc, data);
    end
    repeat (20) @(negedge clk);
    checks++;
    if ((rd_ptr - rd0) != 4 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_start_ignored pops=%0d busy=%b exp pops=4 busy=0", rd_ptr - rd0, busy);
    end
    last_data = 8'h09;
    flush_fifo();
  endtask

  task automatic test_reset_mid();
    int p0;
    set_expr("12A34D");
    load_fifo();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #2;
    checks++;
    if ({op_rd, busy, done, err, ovf, data} !== 13'd0) begin
      errors++;
      $display("[TB] FAIL rstmid_outputs got %b exp all zero", {op_rd, busy, done, err, ovf, data});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_data = 8'h00;
    p0 = rd_ptr;
    repeat (20) @(negedge clk);
    checks++;
    if (rd_ptr != p0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_abort pops_after=%0d busy=%b done=%b exp 0 0 0", rd_ptr - p0, busy, done);
    end
    flush_fifo();
  endtask

  task automatic test_random();
    int mode, n;
    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 3);
      sym_len = 0;
      if (mode == 0) begin
        n = $urandom_range(1, 7);
        for (int k = 0; k < n; k++) begin
          sym_buf[sym_len] = 4'($urandom_range(0, 15));
          sym_len++;
        end
      end else begin
        n = (mode == 1) ? $urandom_range(0, 3) : $urandom_range(1, 2);
        for (int k = 0; k < n; k++) begin sym_buf[sym_len] = 4'($urandom_range(0, 9)); sym_len++; end
        sym_buf[sym_len] = 4'($urandom_range(10, 12));
        sym_len++;
        n = (mode == 1) ? $urandom_range(0, 3) : $urandom_range(1, 2);
        for (int k = 0; k < n; k++) begin sym_buf[sym_len] = 4'($urandom_range(0, 9)); sym_len++; end
        if ($urandom_range(0, 3) != 0) begin sym_buf[sym_len] = 4'hD; sym_len++; end
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) begin sym_buf[sym_len] = 4'($urandom_range(0, 15)); sym_len++; end
      end
      model_eval();
      load_fifo();
      run_expr();
      checks++;
      if (obs_tmo || obs_done !== !exp_err || obs_err !== exp_err || obs_busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rand_flags it=%0d done=%b err=%b busy=%b tmo=%b exp done=%b err=%b", it, obs_done, obs_err, obs_busy, obs_tmo, !exp_err, exp_err);
      end
      checks++;
      if (data !== exp_data || ovf !== exp_ovf) begin
        errors++;
        $display("[TB] FAIL rand_data it=%0d data=%h ovf=%b exp data=%h ovf=%b", it, data, ovf, exp_data, exp_ovf);
      end
      checks++;
      if (obs_pops != exp_pops || (!exp_err && obs_cyc != 2 * exp_pops + 2)) begin
        errors++;
        $display("[TB] FAIL rand_pops it=%0d pops=%0d lat=%0d exp pops=%0d lat=%0d", it, obs_pops, obs_cyc, exp_pops, 2 * exp_pops + 2);
      end
      if (!exp_err) last_data = exp_data;
      flush_fifo();
    end
    checks++;
    if (rd_empty_viol != 0) begin
      errors++;
      $display("[TB] FAIL pop_when_empty count=%0d exp 0", rd_empty_viol);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_syntax_err();
    test_no_equals();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_calc.md
FIFO_CALC -- requirements
Module: fifo_calc

Interface
REQ-001 CLK_50M  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-003 start  input  1  single-cycle debounced pulse; begins evaluation of the queued expression.
REQ-004 op_emp  input  1  symbol FIFO empty flag.
REQ-005 op_data  input  4  symbol FIFO read data; valid the cycle after op_rd.
REQ-006 op_rd  output  1  single-cycle FIFO pop strobe.
REQ-007 data  output  8  result {sign, magnitude[6:0]}; sign=1 means negative.
REQ-008 busy  output  1  high from the cycle after an accepted start until done or err.
REQ-009 done  output  1  single-cycle pulse when data is updated.
REQ-010 err  output  1  sticky syntax-error flag; clears on the next accepted start.
REQ-011 ovf  output  1  sticky overflow flag; clears on the next accepted start.

Function
REQ-012 The block SHALL decode symbols as 0-9 digit, A '+', B '-', C '*', D '=', E/F invalid.
REQ-013 The block SHALL run states IDLE, RD, CAP, N1, OP, N2, CALC, FIN, ERR.
REQ-014 IDLE SHALL accept start only when busy=0; start while busy SHALL be ignored.
REQ-015 RD SHALL assert op_rd for one cycle when op_emp=0, then go to CAP; op_rd SHALL never assert when op_emp=1.
REQ-016 CAP SHALL register op_data and dispatch it to the parse phase (N1, OP or N2) that issued the fetch.
REQ-017 In N1, a digit SHALL update a <= a*10+digit; an operator after at least 1 digit SHALL be stored in OP and the block SHALL advance to N2 fetching.
REQ-018 In N2, a digit SHALL update b the same way; '=' after at least 1 digit SHALL go to CALC.
REQ-019 A third digit in either operand, an operator or '=' with 0 operand digits, a second operator, or an invalid symbol SHALL go to ERR.
REQ-020 FIFO empty in RD: during N1 or before any N2 digit SHALL go to ERR; after at least 1 N2 digit SHALL act as '='.
REQ-021 CALC SHALL compute a+b, a-b or a*b in a 15-bit signed intermediate in one cycle.
REQ-022 A result magnitude >127 SHALL set ovf and saturate the magnitude to 127 with the correct sign.
REQ-023 Zero SHALL be reported as sign=0.
REQ-024 FIN SHALL load data, pulse done and clear busy in the same cycle, then return to IDLE; start-to-done latency = 2 cycles per symbol popped + 2.
REQ-025 ERR SHALL set err, clear busy, leave data unchanged, pulse done=0, and return to IDLE.
REQ-026 An ERR exit SHALL leave unpopped symbols in the FIFO.
REQ-027 data SHALL hold its value until the next FIN.

Reset
REQ-028 reset=0 SHALL force, asynchronously: state IDLE; op_rd, busy, done, err, ovf = 0; data = 8'h00; a, b, operator and digit counters = 0.
REQ-029 reset asserted mid-evaluation SHALL abort with no further op_rd pulses after release until a new start.

Configuration
REQ-030 Macro CALC_MUL_EN defined: symbol C SHALL be multiply.
REQ-031 Macro CALC_MUL_EN undefined: symbol C SHALL be invalid (ERR), and no multiplier SHALL be synthesized.

Verification
REQ-032 FIFO holds 1,2,A,3,4,D; start -> 6 op_rd pulses, data=8'h2E (46), done pulse, err=0, ovf=0.
REQ-033 FIFO holds 3,B,1,2,D; start -> data=8'h89 (-9), done pulse.
REQ-034 FIFO holds 9,9,C,9,9,D with CALC_MUL_EN defined -> data=8'h7F, ovf=1; same symbols without the macro -> err=1 after the C pop, data unchanged.
REQ-035 FIFO holds A,5,D -> err=1 after the first pop, busy=0, FIFO holds 5,D.
REQ-036 FIFO holds 7,B,7 (no '='); start -> data=8'h00, sign=0.
REQ-037 reset pulsed low 3 cycles after start -> all outputs at reset values; a second start pulse during busy has no effect.
